// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
//   arb_state_e : arbiter FSM encoding (2 bits)
package mem_bus_arbiter_pkg;

   localparam int unsigned ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE   = 2'd0,
      ARB_D_BUSY = 2'd1,
      ARB_I_BUSY = 2'd2
   } arb_state_e;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_arb_wdog.sv
// Bus wait watchdog. Only present when MEM_ARB_TIMEOUT_EN is defined.
//   clk, rst  : clock, async active-high reset
//   clr_i     : clear the wait counter (held while the arbiter is idle)
//   en_i      : a wait cycle is being spent (busy and no ack)
//   expire_c  : this wait cycle is the WAIT_MAX-th one
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_wdog #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_c
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q;

   // Counts wait cycles since the last idle cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Fires on the wait cycle that would bring the count up to WAIT_MAX
   assign expire_c = en_i & (cnt_q == CNT_W'(WAIT_MAX - 1));

endmodule : mem_arb_wdog
`endif

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the
// memory-stage data port. Data wins simultaneous requests; each access is
// a bus_req/bus_ack transaction completed by a one-cycle *_vld pulse.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (wait watchdog, bus_err).
//   cpu_clk_50M, cpu_rst             : clock, async active-high reset
//   i_req/i_addr -> i_rdata/i_vld    : fetch port
//   d_req/d_addr/d_we/d_re/d_wdata
//                -> d_rdata/d_vld    : data port
//   bus_err                          : timeout flag, pulses with *_vld
//   stall_if, stall_mem              : combinational stall requests
//   bus_*                            : external memory bus
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_vld,
   input  logic                d_req,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [DATA_W/8-1:0] d_re,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_vld,
   output logic                bus_err,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                bus_req,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata
);

   localparam int unsigned BE_W = DATA_W / 8;
   localparam logic [BE_W-1:0] ARB_BE_ALL = {BE_W{1'b1}};

   arb_state_e state_q;
   logic       expire_c;
   logic       d_new_c;
   logic       i_new_c;

   // A request still high in its own vld cycle is the finished access, not a new one
   assign d_new_c = d_req & ~d_vld;
   assign i_new_c = i_req & ~i_vld;

   assign stall_mem = d_req & ~d_vld;
   assign stall_if  = i_req & ~i_vld;

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_wdog #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wdog (
      .clk      (cpu_clk_50M),
      .rst      (cpu_rst),
      .clr_i    (state_q == ARB_IDLE),
      .en_i     ((state_q != ARB_IDLE) & ~bus_ack),
      .expire_c (expire_c)
   );
`else
   logic unused_wait_max;
   assign unused_wait_max = ^WAIT_MAX;
   assign expire_c        = 1'b0;
`endif

   // Arbiter FSM with registered bus and completion outputs
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q   <= ARB_IDLE;
         bus_req   <= 1'b0;
         bus_addr  <= '0;
         bus_we    <= 1'b0;
         bus_be    <= '0;
         bus_wdata <= '0;
         i_vld     <= 1'b0;
         d_vld     <= 1'b0;
         bus_err   <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_vld   <= 1'b0;
         d_vld   <= 1'b0;
         bus_err <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (d_new_c) begin
                  state_q   <= ARB_D_BUSY;
                  bus_req   <= 1'b1;
                  bus_addr  <= d_addr;
                  bus_we    <= |d_we;
                  bus_be    <= (|d_we) ? d_we : d_re;
                  bus_wdata <= (|d_we) ? d_wdata : '0;
               end else if (i_new_c) begin
                  state_q   <= ARB_I_BUSY;
                  bus_req   <= 1'b1;
                  bus_addr  <= i_addr;
                  bus_we    <= 1'b0;
                  bus_be    <= ARB_BE_ALL;
                  bus_wdata <= '0;
               end
            end
            ARB_D_BUSY: begin
               if (bus_ack || expire_c) begin
                  state_q <= ARB_IDLE;
                  bus_req <= 1'b0;
                  d_vld   <= 1'b1;
                  bus_err <= ~bus_ack;
                  // Stores and timed-out accesses return zero
                  d_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
               end
            end
            ARB_I_BUSY: begin
               if (bus_ack || expire_c) begin
                  state_q <= ARB_IDLE;
                  bus_req <= 1'b0;
                  i_vld   <= 1'b1;
                  bus_err <= ~bus_ack;
                  i_rdata <= bus_ack ? bus_rdata : '0;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change and outputs are sampled
// on the falling edge; "cycle n" below is the n-th falling edge after a
// request is raised.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_vld;
   logic        d_req;
   logic [31:0] d_addr;
   logic [3:0]  d_we;
   logic [3:0]  d_re;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_vld;
   logic        bus_err;
   logic        stall_if;
   logic        stall_mem;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .WAIT_MAX (4)
   ) dut (
      .cpu_clk_50M (clk),
      .cpu_rst     (rst),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_rdata     (i_rdata),
      .i_vld       (i_vld),
      .d_req       (d_req),
      .d_addr      (d_addr),
      .d_we        (d_we),
      .d_re        (d_re),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_vld       (d_vld),
      .bus_err     (bus_err),
      .stall_if    (stall_if),
      .stall_mem   (stall_mem),
      .bus_req     (bus_req),
      .bus_addr    (bus_addr),
      .bus_we      (bus_we),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata)
   );

   task automatic test_reset();
      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
      d_we = '0; d_re = '0; d_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== 70'd0) begin
         n_bad++; $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wd=%h exp all 0",
                           bus_req, bus_we, bus_be, bus_addr, bus_wdata);
      end
      n_cmp++;
      if ({i_vld, d_vld, bus_err, i_rdata, d_rdata} !== 67'd0) begin
         n_bad++; $display("FAIL reset_out: got iv=%b dv=%b err=%b ird=%h drd=%h exp all 0",
                           i_vld, d_vld, bus_err, i_rdata, d_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load();
      d_req = 1'b1; d_addr = 32'h100; d_re = 4'b1111; d_we = 4'b0000;
      #1;
      n_cmp++;
      if (stall_mem !== 1'b1) begin
         n_bad++; $display("FAIL load_stall0: got %b exp 1", stall_mem);
      end
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus_req, bus_we, bus_be, bus_addr, d_vld, stall_mem} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL load_wait c%0d: got req=%b we=%b be=%h addr=%h dv=%b st=%b exp 1 0 f 00000100 0 1",
                              n, bus_req, bus_we, bus_be, bus_addr, d_vld, stall_mem);
         end
         if (n == 4) begin
            bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
         end
      end
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({d_vld, d_rdata, bus_req, stall_mem, bus_err} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL load_done: got dv=%b rd=%h req=%b st=%b err=%b exp 1 deadbeef 0 0 0",
                           d_vld, d_rdata, bus_req, stall_mem, bus_err);
      end
      // d_req still held through the vld cycle must not start a new access
      @(negedge clk);
      n_cmp++;
      if ({d_vld, bus_req, d_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
         n_bad++; $display("FAIL load_after: got dv=%b req=%b rd=%h exp 0 0 deadbeef",
                           d_vld, bus_req, d_rdata);
      end
      d_req = 1'b0; d_re = '0;
      @(negedge clk);
   endtask

   task automatic test_store();
      d_req = 1'b1; d_addr = 32'h201; d_we = 4'b0100; d_re = 4'b0000; d_wdata = 32'h00AB0000;
      for (int n = 1; n <= 2; n++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0100, 32'h201, 32'h00AB0000}) begin
            n_bad++; $display("FAIL store_bus c%0d: got req=%b we=%b be=%b addr=%h wd=%h exp 1 1 0100 00000201 00ab0000",
                              n, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
         end
      end
      bus_ack = 1'b1; bus_rdata = 32'h12345678;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({d_vld, d_rdata, bus_req} !== {1'b1, 32'h0, 1'b0}) begin
         n_bad++; $display("FAIL store_done: got dv=%b rd=%h req=%b exp 1 00000000 0", d_vld, d_rdata, bus_req);
      end
      d_req = 1'b0; d_we = '0; d_wdata = '0;
      @(negedge clk);
   endtask

   task automatic test_priority();
      i_req = 1'b1; i_addr = 32'h400;
      d_req = 1'b1; d_addr = 32'h500; d_re = 4'b0011; d_we = 4'b0000;
      @(negedge clk);
      n_cmp++;
      if ({bus_req, bus_addr, bus_be, stall_if, stall_mem} !== {1'b1, 32'h500, 4'b0011, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL prio_data_first: got req=%b addr=%h be=%b sif=%b smem=%b exp 1 00000500 0011 1 1",
                           bus_req, bus_addr, bus_be, stall_if, stall_mem);
      end
      bus_ack = 1'b1; bus_rdata = 32'hA5A50000;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({d_vld, d_rdata, bus_req, i_vld} !== {1'b1, 32'hA5A50000, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL prio_dvld: got dv=%b rd=%h req=%b iv=%b exp 1 a5a50000 0 0",
                           d_vld, d_rdata, bus_req, i_vld);
      end
      d_req = 1'b0; d_re = '0;
      @(negedge clk);
      n_cmp++;
      if ({bus_req, bus_addr, bus_be, bus_we} !== {1'b1, 32'h400, 4'hF, 1'b0}) begin
         n_bad++; $display("FAIL prio_fetch_grant: got req=%b addr=%h be=%h we=%b exp 1 00000400 f 0",
                           bus_req, bus_addr, bus_be, bus_we);
      end
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({i_vld, i_rdata, stall_if, d_rdata} !== {1'b1, 32'hCAFEF00D, 1'b0, 32'hA5A50000}) begin
         n_bad++; $display("FAIL prio_ivld: got iv=%b ird=%h sif=%b drd=%h exp 1 cafef00d 0 a5a50000",
                           i_vld, i_rdata, stall_if, d_rdata);
      end
      i_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({i_vld, bus_req} !== 2'b00) begin
         n_bad++; $display("FAIL prio_end: got iv=%b req=%b exp 0 0", i_vld, bus_req);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_vld;
      logic [31:0] exp_rd;
      // bus_ack held high throughout, so it also lands in every idle cycle
      i_req = 1'b1; i_addr = 32'h800; bus_ack = 1'b1; bus_rdata = 32'h1000;
      exp_rd = 32'hCAFEF00D;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         exp_vld = (n == 2) || (n == 5) || (n == 8);
         if (exp_vld) exp_rd = 32'h1000 + 32'(n - 1);
         n_cmp++;
         if ({i_vld, i_rdata} !== {exp_vld, exp_rd}) begin
            n_bad++; $display("FAIL b2b c%0d: got iv=%b ird=%h exp %b %h", n, i_vld, i_rdata, exp_vld, exp_rd);
         end
         bus_rdata = 32'h1000 + 32'(n);
         if (n == 8) i_req = 1'b0;
      end
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         n_cmp++;
         if ({i_vld, d_vld, bus_req} !== 3'b000) begin
            n_bad++; $display("FAIL stray_ack c%0d: got iv=%b dv=%b req=%b exp 0 0 0", n, i_vld, d_vld, bus_req);
         end
      end
      bus_ack = 1'b0; bus_rdata = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_addr = 32'h300; d_re = 4'hF; d_we = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus_req !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid_req: got %b exp 0", bus_req);
      end
      d_req = 1'b0; d_re = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         n_cmp++;
         if ({d_vld, bus_req, d_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL rst_mid_after c%0d: got dv=%b req=%b drd=%h exp 0 0 0", n, d_vld, bus_req, d_rdata);
         end
      end
      // Fresh fetch is granted straight away, so the FSM is back in IDLE
      i_req = 1'b1; i_addr = 32'h600;
      @(negedge clk);
      n_cmp++;
      if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h600, 4'hF}) begin
         n_bad++; $display("FAIL rst_mid_idle: got req=%b addr=%h be=%h exp 1 00000600 f", bus_req, bus_addr, bus_be);
      end
      bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({i_vld, i_rdata} !== {1'b1, 32'h0BADF00D}) begin
         n_bad++; $display("FAIL rst_mid_fetch: got iv=%b ird=%h exp 1 0badf00d", i_vld, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clk);
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      i_req = 1'b1; i_addr = 32'h700;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus_req, i_vld, bus_err} !== 3'b100) begin
            n_bad++; $display("FAIL tmo_wait c%0d: got req=%b iv=%b err=%b exp 1 0 0", n, bus_req, i_vld, bus_err);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({bus_req, i_vld, bus_err, i_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         n_bad++; $display("FAIL tmo_expire: got req=%b iv=%b err=%b ird=%h exp 0 1 1 00000000",
                           bus_req, i_vld, bus_err, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({i_vld, bus_err} !== 2'b00) begin
         n_bad++; $display("FAIL tmo_pulse: got iv=%b err=%b exp 0 0", i_vld, bus_err);
      end
   endtask
`else
   task automatic test_timeout();
      i_req = 1'b1; i_addr = 32'h700;
      for (int n = 1; n <= 110; n++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus_req, i_vld, bus_err} !== 3'b100) begin
            n_bad++; $display("FAIL no_tmo c%0d: got req=%b iv=%b err=%b exp 1 0 0", n, bus_req, i_vld, bus_err);
         end
      end
      bus_ack = 1'b1; bus_rdata = 32'h77777777;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = '0;
      n_cmp++;
      if ({i_vld, bus_err, i_rdata} !== {1'b1, 1'b0, 32'h77777777}) begin
         n_bad++; $display("FAIL no_tmo_late_ack: got iv=%b err=%b ird=%h exp 1 0 77777777", i_vld, bus_err, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_store();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mem_bus_arbiter
